// File: rtl/uart_rx_mmio.sv
// rtl/uart_rx_mmio.sv - memory-mapped UART receiver with receive FIFO and level interrupt
// Ports: clk, reset (async, active-high); rd/wr/addr/wdata/rdata bus responder port;
//        rx serial input (idle high); kernel_mode masks irq; irq level interrupt.
module uart_rx_mmio #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  input  logic        kernel_mode,
  output logic        irq
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  localparam logic [31:0] ADDR_RXDATA = 32'h4000_001C;
  localparam logic [31:0] ADDR_RXSTAT = 32'h4000_0020;
  localparam logic [31:0] ADDR_RXCTRL = 32'h4000_0024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          sync1_q, rxs_q;
  logic          stop_good, stop_bad;

  logic          rx_en_q, irq_en_q;
  logic          overrun_q, frame_err_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic          sel_data, sel_stat, sel_ctrl;
  logic          not_empty, full, push, pop, ovr_set;
  logic          clr_ovr, clr_ferr;
  logic [31:0]   stat_w;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    if (!rx_en_q) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_d = S_START;
            // The cycle in which rxs first read low is already one tick into the start bit.
            tick_d  = TICK_ONE;
          end
        end
        S_START: begin
          if (tick_q == TICK_HALF) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rxs_q ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        S_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d         = '0;
            shift_d[bit_q] = rxs_q;
            if (bit_q == 3'd7) state_d = S_STOP;
            else               bit_d   = bit_q + 3'd1;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        S_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (rxs_q) begin
              stop_good = 1'b1;
              state_d   = S_IDLE;
            end else begin
              stop_bad  = 1'b1;
              state_d   = S_WAIT_HIGH;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
        S_WAIT_HIGH: begin
          if (rxs_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign sel_data  = (addr == ADDR_RXDATA);
  assign sel_stat  = (addr == ADDR_RXSTAT);
  assign sel_ctrl  = (addr == ADDR_RXCTRL);

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pop       = rd & sel_data & not_empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
  assign push      = stop_good & (~full | pop);
  assign ovr_set   = stop_good & full & ~pop;
  assign clr_ovr   = wr & sel_stat & wdata[2];
  assign clr_ferr  = wr & sel_stat & wdata[3];

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= shift_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_en_q     <= 1'b0;
      irq_en_q    <= 1'b0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      // Set takes priority over a simultaneous write-1-to-clear.
      overrun_q   <= ovr_set  | (overrun_q   & ~clr_ovr);
      frame_err_q <= stop_bad | (frame_err_q & ~clr_ferr);
      if (wr && sel_ctrl) begin
        rx_en_q  <= wdata[0];
        irq_en_q <= wdata[1];
      end
    end
  end

  always_comb begin
    stat_w           = '0;
    stat_w[0]        = not_empty;
    stat_w[1]        = full;
    stat_w[2]        = overrun_q;
    stat_w[3]        = frame_err_q;
    stat_w[4 +: CW]  = count_q;
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_data && not_empty) rdata = {24'b0, mem_q[head_q]};
      else if (sel_stat)         rdata = stat_w;
      else if (sel_ctrl)         rdata = {30'b0, irq_en_q, rx_en_q};
    end
  end

  assign irq = irq_en_q & not_empty & ~kernel_mode;

endmodule
